bus_mem_responder: RTL
======================

BUS_MEM_RESPONDER -- requirements
Module: bus_mem_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, the byte address of memory word 0.
REQ-002 SHALL have parameter MEM_WORDS, default 256, the memory depth in BUS_DW-bit words.
REQ-003 SHALL have parameter RSP_DEPTH, default 4, the response FIFO depth (at least 2).
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port req_valid_i, input, 1 bit: request valid.
REQ-007 SHALL have port req_ready_o, output, 1 bit: request accepted when valid and ready are both high.
REQ-008 SHALL have port req_addr_i, input, BUS_AW bits: byte address.
REQ-009 SHALL have port req_write_i, input, 1 bit: 1 = write, 0 = read.
REQ-010 SHALL have port req_wdata_i, input, BUS_DW bits: write data.
REQ-011 SHALL have port req_mask_i, input, BUS_DBW bits: write byte-lane enables.
REQ-012 SHALL have port req_size_i, input, BUS_SZW bits: transfer of 2^size bytes.
REQ-013 SHALL have port req_id_i, input, BUS_IDW bits: transaction ID.
REQ-014 SHALL have port rsp_valid_o, output, 1 bit: response valid.
REQ-015 SHALL have port rsp_ready_i, input, 1 bit: response consumed when valid and ready are both high.
REQ-016 SHALL have port rsp_rdata_o, output, BUS_DW bits: read data.
REQ-017 SHALL have port rsp_id_o, output, BUS_IDW bits: the ID echoed from the request.
REQ-018 SHALL have port rsp_error_o, output, 1 bit: error response.

Function
REQ-019 SHALL drive req_ready_o = rst_ni AND (FIFO occupancy < RSP_DEPTH), with no combinational path from rsp_ready_i.
REQ-020 SHALL perform the memory access in the accept cycle: masked write at that edge; read of the full word at (addr-BASE_ADDR)>>2.
REQ-021 SHALL push {rdata, id, error} into the FIFO on accept, with rsp_valid_o high no earlier than the next cycle (minimum latency 1).
REQ-022 SHALL flag an error when: size > log2(BUS_DBW); or addr is misaligned to 2^size; or addr < BASE_ADDR; or word index >= MEM_WORDS.
REQ-023 SHALL, on an error, leave memory unmodified and return rdata 0.
REQ-024 SHALL return rdata 0 for a successful write.
REQ-025 SHALL present responses strictly in acceptance order, regardless of ID.
REQ-026 SHALL keep rsp_* stable while rsp_valid_o is high and rsp_ready_i is low.
REQ-027 SHALL, on a simultaneous push and pop, leave occupancy unchanged; at occupancy RSP_DEPTH, push is impossible and a pop re-enables req_ready_o next cycle.
REQ-028 SHALL, on a read-after-write to the same word in back-to-back accepts, return the newly written data.
REQ-029 SHALL wrap the FIFO read and write pointers modulo RSP_DEPTH.
REQ-030 SHALL drive rsp_rdata_o, rsp_id_o and rsp_error_o to 0 whenever rsp_valid_o is low.

Reset
REQ-031 SHALL, while rst_ni is low at an edge, clear occupancy and pointers, set rsp_valid_o = 0, and drive rdata, id and error to 0.
REQ-032 SHALL hold req_ready_o at 0 while rst_ni is low.
REQ-033 SHALL discard all buffered responses on a reset mid-operation.
REQ-034 SHALL NOT reset memory contents, and SHALL block writes during reset.

Structure
REQ-035 SHALL take BUS_AW, BUS_DW, BUS_DBW, BUS_SZW and BUS_IDW from bus_params_pkg.
REQ-036 SHALL define the typedefs bus_req_t and bus_rsp_t in bus_params_pkg.
REQ-037 SHALL implement the response buffer as sub-module bus_rsp_fifo, parameterised on depth and entry type.

Verification
REQ-038 SHALL cover: write 0xDEADBEEF to 0x10 with mask 4'hF, size 2, id 3, then read 0x10 with id 5 -> responses {0, id 3, err 0} then {0xDEADBEEF, id 5, err 0}.
REQ-039 SHALL cover: byte write 0xAA to 0x11 with mask 4'b0010, size 0, after the REQ-038 write -> read 0x10 returns 0xDEADAAEF.
REQ-040 SHALL cover: halfword read at 0x13, a size 3 access, and an access at 0x400 with MEM_WORDS = 256 -> each responds err 1, rdata 0, and memory is unchanged.
REQ-041 SHALL cover: rsp_ready_i held 0 while 5 requests are offered -> exactly 4 accepted, req_ready_o falls, and after one pop the 5th is accepted next cycle; IDs return in order.
REQ-042 SHALL cover: rsp_ready_i held 1 and a request every cycle -> throughput of 1 per cycle, latency 1, occupancy at most 1.
REQ-043 SHALL cover: rst_ni pulled low for 1 cycle with 3 responses pending -> rsp_valid_o is 0 the next cycle, and a subsequent read sees the pre-reset memory data.

Source files
------------

// File: rtl/bus_params_pkg.sv
// Shared bus geometry, request/response records and a small alignment helper
// for the memory-mapped responder.
package bus_params_pkg;

  localparam int BUS_AW     = 32;
  localparam int BUS_DW     = 32;
  localparam int BUS_DBW    = BUS_DW / 8;
  localparam int BUS_SZW    = 2;
  localparam int BUS_IDW    = 4;
  localparam int BUS_LG_DBW = $clog2(BUS_DBW);

  typedef struct packed {
    logic [BUS_AW-1:0]  addr;
    logic               write;
    logic [BUS_DW-1:0]  wdata;
    logic [BUS_DBW-1:0] mask;
    logic [BUS_SZW-1:0] size;
    logic [BUS_IDW-1:0] id;
  } bus_req_t;

  typedef struct packed {
    logic [BUS_DW-1:0]  rdata;
    logic [BUS_IDW-1:0] id;
    logic               error;
  } bus_rsp_t;

  // Low address bits that must be zero for a naturally aligned 2^size access.
  function automatic logic [BUS_AW-1:0] size_align_mask(input logic [BUS_SZW-1:0] size);
    return (BUS_AW'(1) << size) - BUS_AW'(1);
  endfunction

endpackage

// File: rtl/bus_rsp_fifo.sv
// Generic in-order response buffer; depth need not be a power of two, so the
// pointers wrap explicitly at DEPTH-1.
module bus_rsp_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [31:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     pop_data,
  output logic empty,
  output logic full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  T                 store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (cnt == '0);
  assign full     = (cnt == CNT_W'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/bus_mem_responder.sv
// Single-cycle memory target: the access happens in the accept cycle and the
// response is queued in an in-order FIFO that the requester drains at will.
module bus_mem_responder
  import bus_params_pkg::*;
#(
  parameter logic [BUS_AW-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int                MEM_WORDS = 256,
  parameter int                RSP_DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [BUS_AW-1:0]  req_addr_i,
  input  logic               req_write_i,
  input  logic [BUS_DW-1:0]  req_wdata_i,
  input  logic [BUS_DBW-1:0] req_mask_i,
  input  logic [BUS_SZW-1:0] req_size_i,
  input  logic [BUS_IDW-1:0] req_id_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [BUS_DW-1:0]  rsp_rdata_o,
  output logic [BUS_IDW-1:0] rsp_id_o,
  output logic               rsp_error_o
);

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [BUS_DW-1:0] mem [MEM_WORDS];

  bus_req_t          req_p0;
  bus_rsp_t          rsp_p0;
  bus_rsp_t          rsp_p1;
  logic              vld_p1;
  logic              accept_p0;
  logic              err_p0;
  logic [BUS_AW-1:0] offset_p0;
  logic [BUS_AW-1:0] word_off_p0;
  logic [IDX_W-1:0]  word_idx_p0;
  logic              fifo_empty;
  logic              fifo_full;

  function automatic logic access_error(input bus_req_t r, input logic [BUS_AW-1:0] word_off);
    logic bad_size;
    logic misaligned;
    logic below_base;
    logic beyond_end;
    bad_size   = (r.size > BUS_SZW'(BUS_LG_DBW));
    misaligned = ((r.addr & size_align_mask(r.size)) != '0);
    below_base = (r.addr < BASE_ADDR);
    beyond_end = (word_off >= BUS_AW'(MEM_WORDS));
    return bad_size || misaligned || below_base || beyond_end;
  endfunction

  // Stage p0: decode, memory access and response formation in the accept cycle
  assign req_p0 = '{addr:  req_addr_i,
                    write: req_write_i,
                    wdata: req_wdata_i,
                    mask:  req_mask_i,
                    size:  req_size_i,
                    id:    req_id_i};

  // Readiness depends only on registered occupancy, never on rsp_ready_i.
  assign req_ready_o = rst_ni && !fifo_full;
  assign accept_p0   = req_valid_i && req_ready_o;

  assign offset_p0   = req_p0.addr - BASE_ADDR;
  assign word_off_p0 = offset_p0 >> BUS_LG_DBW;
  assign word_idx_p0 = word_off_p0[IDX_W-1:0];
  assign err_p0      = access_error(req_p0, word_off_p0);

  assign rsp_p0.rdata = (err_p0 || req_p0.write) ? '0 : mem[word_idx_p0];
  assign rsp_p0.id    = req_p0.id;
  assign rsp_p0.error = err_p0;

  always_ff @(posedge clk_i) begin
    if (accept_p0 && req_p0.write && !err_p0) begin
      for (int b = 0; b < BUS_DBW; b++) begin
        if (req_p0.mask[b]) mem[word_idx_p0][8*b +: 8] <= req_p0.wdata[8*b +: 8];
      end
    end
  end

  bus_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .T     (bus_rsp_t)
  ) u_rsp_fifo (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .push      (accept_p0),
    .push_data (rsp_p0),
    .pop       (rsp_ready_i),
    .pop_data  (rsp_p1),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Stage p1: FIFO head, zeroed whenever no response is offered
  assign vld_p1      = !fifo_empty;
  assign rsp_valid_o = vld_p1;
  assign rsp_rdata_o = vld_p1 ? rsp_p1.rdata : '0;
  assign rsp_id_o    = vld_p1 ? rsp_p1.id    : '0;
  assign rsp_error_o = vld_p1 ? rsp_p1.error : 1'b0;

endmodule
